// File: rtl/axi_lite_master_seq.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_master_seq
// Description : Single-outstanding AXI4-Lite master sequencer. It turns one
//               command into a read or write burst, with a per-phase timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_master_seq #(
    parameter int TIMEOUT = 255
) (
    input  logic        S_ACLK,
    input  logic        S_ARRESET_N,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        M_AWVALID,
    output logic [31:0] M_AWADDR,
    input  logic        S_AWREADY,
    output logic        M_WVALID,
    output logic [31:0] M_WDATA,
    output logic [3:0]  M_WSTRB,
    input  logic        S_WREADY,
    input  logic        S_BVALID,
    input  logic [1:0]  S_BRESP,
    output logic        M_BREADY,
    output logic        M_ARVALID,
    output logic [31:0] M_ARADDR,
    input  logic        S_ARREADY,
    input  logic        S_RVALID,
    input  logic [31:0] S_RDATA,
    output logic        M_RREADY
);

    localparam logic [15:0] c_timeout   = 16'(TIMEOUT);
    localparam logic [1:0]  c_resp_okay = 2'b00;
    localparam logic [1:0]  c_resp_tout = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic [1:0]  r_rsp_resp;
    logic        r_awvalid;
    logic [31:0] r_awaddr;
    logic        r_wvalid;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_bready;
    logic        r_arvalid;
    logic [31:0] r_araddr;
    logic        r_rready;

    state_t      w_state_nxt;
    logic [15:0] w_cnt_nxt;
    logic        w_cmd_ready_nxt;
    logic        w_rsp_valid_nxt;
    logic [31:0] w_rsp_rdata_nxt;
    logic [1:0]  w_rsp_resp_nxt;
    logic        w_awvalid_nxt;
    logic [31:0] w_awaddr_nxt;
    logic        w_wvalid_nxt;
    logic [31:0] w_wdata_nxt;
    logic [3:0]  w_wstrb_nxt;
    logic        w_bready_nxt;
    logic        w_arvalid_nxt;
    logic [31:0] w_araddr_nxt;
    logic        w_rready_nxt;
    logic        w_abort;

    logic w_aw_done;
    logic w_w_done;
    logic w_timeout;

    // A channel counts as done once its valid has already dropped or its ready arrives now.
    assign w_aw_done = !r_awvalid || S_AWREADY;
    assign w_w_done  = !r_wvalid  || S_WREADY;
    assign w_timeout = (r_cnt == c_timeout);

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = '0;
        w_cmd_ready_nxt = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_resp_nxt  = r_rsp_resp;
        w_awvalid_nxt   = r_awvalid;
        w_awaddr_nxt    = r_awaddr;
        w_wvalid_nxt    = r_wvalid;
        w_wdata_nxt     = r_wdata;
        w_wstrb_nxt     = r_wstrb;
        w_bready_nxt    = r_bready;
        w_arvalid_nxt   = r_arvalid;
        w_araddr_nxt    = r_araddr;
        w_rready_nxt    = r_rready;
        w_abort         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cmd_ready_nxt = 1'b1;
                if (cmd_valid && r_cmd_ready) begin
                    w_cmd_ready_nxt = 1'b0;
                    if (cmd_write) begin
                        w_state_nxt   = ST_WR_REQ;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_awaddr_nxt  = cmd_addr;
                        w_wdata_nxt   = cmd_wdata;
                        w_wstrb_nxt   = cmd_wstrb;
                    end else begin
                        w_state_nxt   = ST_RD_REQ;
                        w_arvalid_nxt = 1'b1;
                        w_araddr_nxt  = cmd_addr;
                    end
                end
            end

            // Timeout is checked first: reaching the limit aborts even if a ready arrives that cycle.
            ST_WR_REQ: begin
                if (w_timeout) begin
                    w_abort = 1'b1;
                end else if (w_aw_done && w_w_done) begin
                    w_state_nxt   = ST_WR_RESP;
                    w_awvalid_nxt = 1'b0;
                    w_wvalid_nxt  = 1'b0;
                    w_bready_nxt  = 1'b1;
                end else begin
                    if (S_AWREADY) w_awvalid_nxt = 1'b0;
                    if (S_WREADY)  w_wvalid_nxt  = 1'b0;
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end

            ST_WR_RESP: begin
                if (w_timeout) begin
                    w_abort = 1'b1;
                end else if (S_BVALID) begin
                    w_state_nxt     = ST_DONE;
                    w_bready_nxt    = 1'b0;
                    w_rsp_resp_nxt  = S_BRESP;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_valid_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end

            ST_RD_REQ: begin
                if (w_timeout) begin
                    w_abort = 1'b1;
                end else if (S_ARREADY) begin
                    w_state_nxt   = ST_RD_DATA;
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end

            ST_RD_DATA: begin
                if (w_timeout) begin
                    w_abort = 1'b1;
                end else if (S_RVALID) begin
                    w_state_nxt     = ST_DONE;
                    w_rready_nxt    = 1'b0;
                    w_rsp_resp_nxt  = c_resp_okay;
                    w_rsp_rdata_nxt = S_RDATA;
                    w_rsp_valid_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end

            ST_DONE: begin
                w_state_nxt     = ST_IDLE;
                w_cmd_ready_nxt = 1'b1;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_abort) begin
            w_state_nxt     = ST_DONE;
            w_awvalid_nxt   = 1'b0;
            w_wvalid_nxt    = 1'b0;
            w_bready_nxt    = 1'b0;
            w_arvalid_nxt   = 1'b0;
            w_rready_nxt    = 1'b0;
            w_rsp_resp_nxt  = c_resp_tout;
            w_rsp_rdata_nxt = '0;
            w_rsp_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge S_ACLK or negedge S_ARRESET_N) begin
        if (!S_ARRESET_N) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
            r_awvalid   <= 1'b0;
            r_awaddr    <= '0;
            r_wvalid    <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_araddr    <= '0;
            r_rready    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_resp  <= w_rsp_resp_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_awaddr    <= w_awaddr_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wstrb     <= w_wstrb_nxt;
            r_bready    <= w_bready_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_araddr    <= w_araddr_nxt;
            r_rready    <= w_rready_nxt;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_resp  = r_rsp_resp;
    assign M_AWVALID = r_awvalid;
    assign M_AWADDR  = r_awaddr;
    assign M_WVALID  = r_wvalid;
    assign M_WDATA   = r_wdata;
    assign M_WSTRB   = r_wstrb;
    assign M_BREADY  = r_bready;
    assign M_ARVALID = r_arvalid;
    assign M_ARADDR  = r_araddr;
    assign M_RREADY  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_master_seq
// Description : Directed, table-driven bench for axi_lite_master_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_master_seq;

    localparam int c_tout  = 8;
    localparam int c_never = 999;

    logic        S_ACLK;
    logic        S_ARRESET_N;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        M_AWVALID;
    logic [31:0] M_AWADDR;
    logic        S_AWREADY;
    logic        M_WVALID;
    logic [31:0] M_WDATA;
    logic [3:0]  M_WSTRB;
    logic        S_WREADY;
    logic        S_BVALID;
    logic [1:0]  S_BRESP;
    logic        M_BREADY;
    logic        M_ARVALID;
    logic [31:0] M_ARADDR;
    logic        S_ARREADY;
    logic        S_RVALID;
    logic [31:0] S_RDATA;
    logic        M_RREADY;

    int n_err;
    int n_chk;

    axi_lite_master_seq #(.TIMEOUT(c_tout)) u_dut (
        .S_ACLK      (S_ACLK),
        .S_ARRESET_N (S_ARRESET_N),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .M_AWVALID   (M_AWVALID),
        .M_AWADDR    (M_AWADDR),
        .S_AWREADY   (S_AWREADY),
        .M_WVALID    (M_WVALID),
        .M_WDATA     (M_WDATA),
        .M_WSTRB     (M_WSTRB),
        .S_WREADY    (S_WREADY),
        .S_BVALID    (S_BVALID),
        .S_BRESP     (S_BRESP),
        .M_BREADY    (M_BREADY),
        .M_ARVALID   (M_ARVALID),
        .M_ARADDR    (M_ARADDR),
        .S_ARREADY   (S_ARREADY),
        .S_RVALID    (S_RVALID),
        .S_RDATA     (S_RDATA),
        .M_RREADY    (M_RREADY)
    );

    initial S_ACLK = 1'b0;
    always #5 S_ACLK = ~S_ACLK;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        int          b_dly;
        logic [1:0]  bresp;
        int          ar_dly;
        int          r_dly;
        logic [31:0] rdata;
        int          exp_aw;
        int          exp_w;
        int          exp_ar;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge S_ACLK);
        #1;
    endtask

    task automatic slave_idle();
        S_AWREADY = 1'b0;
        S_WREADY  = 1'b0;
        S_BVALID  = 1'b0;
        S_BRESP   = 2'b00;
        S_ARREADY = 1'b0;
        S_RVALID  = 1'b0;
        S_RDATA   = '0;
    endtask

    // Issues one command and plays a slave that raises each ready/valid after a set number of cycles.
    task automatic run_vec(input vec_t v, input int idx);
        int  aw_n, w_n, b_n, ar_n, r_n, bad, cyc;
        bit  done;
        aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0; bad = 0; done = 1'b0;
        cyc = 0;
        while (!cmd_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_wstrb = v.strb;
        tick();
        cmd_valid = 1'b0;
        cmd_addr  = ~v.addr;
        cmd_wdata = ~v.wdata;
        cmd_wstrb = ~v.strb;
        for (int c = 0; c < 40 && !done; c++) begin
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                if (M_AWVALID) begin
                    aw_n++;
                    if (M_AWADDR !== v.addr) bad++;
                end
                if (M_WVALID) begin
                    w_n++;
                    if (M_WDATA !== v.wdata || M_WSTRB !== v.strb) bad++;
                end
                if (M_ARVALID) begin
                    ar_n++;
                    if (M_ARADDR !== v.addr) bad++;
                end
                if (M_BREADY) b_n++;
                if (M_RREADY) r_n++;
                S_AWREADY = M_AWVALID && (aw_n - 1 >= v.aw_dly);
                S_WREADY  = M_WVALID  && (w_n - 1 >= v.w_dly);
                S_BVALID  = M_BREADY  && (b_n - 1 >= v.b_dly);
                S_BRESP   = v.bresp;
                S_ARREADY = M_ARVALID && (ar_n - 1 >= v.ar_dly);
                S_RVALID  = M_RREADY  && (r_n - 1 >= v.r_dly);
                S_RDATA   = v.rdata;
                tick();
            end
        end
        slave_idle();
        check($sformatf("v%0d completion", idx), 32'(done), 32'd1);
        check($sformatf("v%0d rsp_resp", idx), 32'(rsp_resp), 32'(v.exp_resp));
        check($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
        check($sformatf("v%0d stable payload", idx), 32'(bad), 32'd0);
        if (v.wr) begin
            check($sformatf("v%0d awvalid cycles", idx), 32'(aw_n), 32'(v.exp_aw));
            check($sformatf("v%0d wvalid cycles", idx), 32'(w_n), 32'(v.exp_w));
        end else begin
            check($sformatf("v%0d arvalid cycles", idx), 32'(ar_n), 32'(v.exp_ar));
        end
        tick();
        check($sformatf("v%0d rsp_valid one cycle", idx), 32'(rsp_valid), 32'd0);
        check($sformatf("v%0d cmd_ready back", idx), 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, pulses, bad, cyc;
        n_err = 0;
        n_chk = 0;

        //              wr  addr          wdata         strb  aw w  b  bresp ar       r        rdata         eaw ew ear eresp  erdata
        vecs[0]  = '{1'b1, 32'h0000_0004, 32'hA5A5_1234, 4'hF, 0, 0, 0, 2'b00, 0,       0,       32'h0,         1, 1, 0, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 0, 0, 0, 2'b00, 3,       2,       32'hA5A5_1234, 0, 0, 4, 2'b00, 32'hA5A5_1234};
        vecs[2]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'h3, 0, 4, 1, 2'b00, 0,       0,       32'h0,         1, 5, 0, 2'b00, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_0020, 32'h5566_7788, 4'hC, 5, 0, 0, 2'b10, 0,       0,       32'h0,         6, 1, 0, 2'b10, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0030, 32'h0,         4'h0, 0, 0, 0, 2'b00, c_never, 0,       32'h1111_1111, 0, 0, 9, 2'b10, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0034, 32'h0,         4'h0, 0, 0, 0, 2'b00, 0,       0,       32'hDEAD_BEEF, 0, 0, 1, 2'b00, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b1, 32'h0000_0040, 32'hCAFE_0001, 4'h1, 0, 0, c_never, 2'b00, 0, 0,       32'h0,         1, 1, 0, 2'b10, 32'h0};
        vecs[7]  = '{1'b1, 32'h0000_0044, 32'hCAFE_0002, 4'h8, c_never, 2, 0, 2'b00, 0, 0,       32'h0,         9, 3, 0, 2'b10, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_0048, 32'h0,         4'h0, 0, 0, 0, 2'b00, 0,       c_never, 32'h2222_2222, 0, 0, 1, 2'b10, 32'h0};
        vecs[9]  = '{1'b1, 32'h0000_004C, 32'h0BAD_F00D, 4'h6, 1, 1, 3, 2'b01, 0,       0,       32'h0,         2, 2, 0, 2'b01, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_0050, 32'h0,         4'h0, 0, 0, 0, 2'b00, 7,       7,       32'h1357_9BDF, 0, 0, 8, 2'b00, 32'h1357_9BDF};

        S_ARRESET_N = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        slave_idle();

        // Reset state, before and after clock edges while held in reset
        #2;
        check("reset cmd_ready", 32'(cmd_ready), 32'd0);
        check("reset valids", 32'({M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid}), 32'd0);
        tick();
        tick();
        check("reset held cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge S_ACLK);
        S_ARRESET_N = 1'b1;
        tick();
        check("first edge cmd_ready", 32'(cmd_ready), 32'd1);

        // Stray responses in IDLE must not produce a completion
        S_BVALID = 1'b1;
        S_RVALID = 1'b1;
        S_RDATA  = 32'hFFFF_FFFF;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rsp_valid || !cmd_ready) pulses++;
        end
        slave_idle();
        check("stray responses ignored", 32'(pulses), 32'd0);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // cmd_valid held through the busy period, slave always ready, BRESP=SLVERR
        acc = 0; pulses = 0; bad = 0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0060;
        cmd_wdata = 32'h0F0F_0F0F;
        cmd_wstrb = 4'hF;
        for (int i = 0; i < 20; i++) begin
            if (cmd_valid && cmd_ready) acc++;
            if (rsp_valid) begin
                pulses++;
                if (rsp_resp !== 2'b10) bad++;
            end
            S_AWREADY = M_AWVALID;
            S_WREADY  = M_WVALID;
            S_BVALID  = M_BREADY;
            S_BRESP   = 2'b10;
            tick();
        end
        cmd_valid = 1'b0;
        slave_idle();
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) pulses++;
            tick();
        end
        check("held cmd accepts", 32'(acc), 32'd5);
        check("held cmd pulses", 32'(pulses), 32'd5);
        check("held cmd bresp", 32'(bad), 32'd0);

        // Asynchronous reset while waiting in WR_RESP
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0070;
        cmd_wdata = 32'h7777_7777;
        cmd_wstrb = 4'hF;
        tick();
        cmd_valid = 1'b0;
        cyc = 0;
        while (!M_BREADY && cyc < 20) begin
            S_AWREADY = M_AWVALID;
            S_WREADY  = M_WVALID;
            tick();
            cyc++;
        end
        slave_idle();
        check("reached WR_RESP", 32'(M_BREADY), 32'd1);
        #2;
        S_ARRESET_N = 1'b0;
        #1;
        check("async reset ctrl", 32'({cmd_ready, M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid}), 32'd0);
        check("async reset data", M_AWADDR | M_WDATA | M_ARADDR | rsp_rdata, 32'd0);
        check("async reset strb/resp", 32'({M_WSTRB, rsp_resp}), 32'd0);
        @(negedge S_ACLK);
        S_ARRESET_N = 1'b1;
        #1;
        check("before first edge cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        check("after release cmd_ready", 32'(cmd_ready), 32'd1);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) pulses++;
            tick();
        end
        check("no pulse after reset abort", 32'(pulses), 32'd0);

        // Next command after a timeout/reset still works end to end
        run_vec(vecs[5], 11);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_master_seq.md
AXI_LITE_MASTER_SEQ -- requirements
Module: axi_lite_master_seq

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, the maximum cycles spent waiting in any one AXI phase before abort (legal range 1..65535).
REQ-002 S_ACLK  input  1  the single clock; all state SHALL change on its rising edge.
REQ-003 S_ARRESET_N  input  1  the reset, asynchronous and active-low.
REQ-004 cmd_valid  input  1  a command is offered.
REQ-005 cmd_ready  output  1  the block can accept a command.
REQ-006 cmd_write  input  1  1 = write command, 0 = read command.
REQ-007 cmd_addr  input  32  target byte address.
REQ-008 cmd_wdata  input  32  write data.
REQ-009 cmd_wstrb  input  4  write byte strobes.
REQ-010 rsp_valid  output  1  one-cycle pulse that marks command completion.
REQ-011 rsp_rdata  output  32  read data; 0 for writes and aborted commands.
REQ-012 rsp_resp  output  2  completion status: 00 OKAY, BRESP value for writes, 10 on timeout.
REQ-013 M_AWVALID  output  1  write address valid.
REQ-014 M_AWADDR  output  32  write address.
REQ-015 S_AWREADY  input  1  slave accepts the write address.
REQ-016 M_WVALID  output  1  write data valid.
REQ-017 M_WDATA  output  32  write data.
REQ-018 M_WSTRB  output  4  write strobes.
REQ-019 S_WREADY  input  1  slave accepts the write data.
REQ-020 S_BVALID  input  1  write response valid.
REQ-021 S_BRESP  input  2  write response code.
REQ-022 M_BREADY  output  1  the block can accept a write response.
REQ-023 M_ARVALID  output  1  read address valid.
REQ-024 M_ARADDR  output  32  read address.
REQ-025 S_ARREADY  input  1  slave accepts the read address.
REQ-026 S_RVALID  input  1  read data valid.
REQ-027 S_RDATA  input  32  read data.
REQ-028 M_RREADY  output  1  the block can accept read data.

Function
REQ-029 The block SHALL implement the states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA and DONE, and all outputs SHALL be driven from registers.
REQ-030 cmd_ready SHALL be 1 only in IDLE; when cmd_valid and cmd_ready are both 1, the block SHALL latch addr, wdata and wstrb, then go to WR_REQ if cmd_write is 1, otherwise RD_REQ.
REQ-031 On entry to WR_REQ, M_AWVALID and M_WVALID SHALL both rise together on the cycle after acceptance.
REQ-032 In WR_REQ, each of M_AWVALID and M_WVALID SHALL clear independently on the edge where its own ready is sampled 1, and its address, data and strobes SHALL stay stable until then.
REQ-033 When both the AW and W handshakes are complete, including the case where both readies arrive in the same cycle, the block SHALL go to WR_RESP with M_BREADY=1 on the next cycle.
REQ-034 In WR_RESP, on S_BVALID=1 the block SHALL capture S_BRESP into rsp_resp, clear M_BREADY, set rsp_rdata=0 and go to DONE.
REQ-035 In RD_REQ, M_ARVALID SHALL stay 1 until S_ARREADY is sampled 1; the block SHALL then go to RD_DATA with M_RREADY=1.
REQ-036 In RD_DATA, on S_RVALID=1 the block SHALL capture S_RDATA, set rsp_resp=00, clear M_RREADY and go to DONE.
REQ-037 In DONE, rsp_valid SHALL be 1 for exactly one cycle and the next state SHALL be IDLE; consecutive command acceptances are therefore at least 4 cycles apart.
REQ-038 A 16-bit wait counter SHALL clear on entry to WR_REQ, WR_RESP, RD_REQ and RD_DATA, and SHALL increment on each cycle the phase is not complete.
REQ-039 When the wait counter equals TIMEOUT, the block SHALL drop all M_*VALID and M_*READY outputs, set rsp_resp=10 and rsp_rdata=0, and go to DONE.
REQ-040 Any S_BVALID or S_RVALID that arrives outside WR_RESP or RD_DATA SHALL be ignored.
REQ-041 cmd_* inputs SHALL be ignored outside IDLE.

Reset
REQ-042 While S_ARRESET_N=0, immediately and without waiting for a clock edge: state = IDLE, every output = 0 except cmd_ready = 0, and the wait counter = 0.
REQ-043 On the first rising edge after reset release, cmd_ready SHALL become 1; a reset mid-command SHALL abort the command with no rsp_valid pulse.

Verification
REQ-044 Write 0xA5A5_1234 to addr 0x4 with strb 0xF, slave readies high -> AW and W valids high for 1 cycle, M_BREADY asserted; BRESP=00 gives rsp_valid pulse with rsp_resp=00.
REQ-045 Read addr 0x4 after the write in REQ-044; ARREADY delayed 3 cycles, RVALID delayed 2 cycles -> M_ARADDR=0x4 held for 4 cycles, rsp_rdata=0xA5A5_1234.
REQ-046 Write with S_AWREADY at cycle 1 and S_WREADY at cycle 5 -> M_AWVALID drops after cycle 1, M_WVALID holds until cycle 5, then WR_RESP.
REQ-047 TIMEOUT=8 and the slave never asserts S_ARREADY -> M_ARVALID drops after 8 wait cycles, rsp_resp=10, rsp_rdata=0, and the next command is accepted.
REQ-048 S_ARRESET_N pulsed low during WR_RESP -> all outputs 0 immediately, no rsp_valid pulse, cmd_ready=1 on the first edge after release.
REQ-049 BRESP=10 returned by the slave -> rsp_resp=10; cmd_valid held high during the busy period -> exactly one command accepted per rsp_valid pulse.
